// File: rtl/mux_seq_pkg.sv
// Shared constants, FSM state encoding and the one-hot helper for the round-robin mux select sequencer.
// Used by rr_pick4 and mux_rr_select_seq.
package mux_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_select_seq_rr_pick4.sv
// Combinational round-robin picker for four requesters.
// The search starts one past ptr and wraps, so the last winner is considered last.
module rr_pick4
    import mux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              any,
    output logic [SEL_W-1:0]  win
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        win   = ptr;
        found = 1'b0;
        cand  = '0;
        // k wraps to 0 at NUM_CH, so the final candidate is ptr itself.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_rr_select_seq.sv
// Round-robin select sequencer driving the s1/s0 lines of a downstream 4:1 mux, with bounded dwell.
// Optional macro MUX_SEQ_LOCK_EN adds a lock input that holds a grant past its dwell limit.
module mux_rr_select_seq
    import mux_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef MUX_SEQ_LOCK_EN
    input  logic       lock,
`endif
    output logic       s0,
    output logic       s1,
    output logic [3:0] grant,
    output logic       valid,
    output logic       switch_pulse
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              switch_q, switch_d;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_win;
    logic              lock_hold;
    logic              rearb;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

`ifdef MUX_SEQ_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // In GRANT, sel_q is the current holder's index.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        rearb    = 1'b0;
        switch_d = 1'b0;

        case (state_q)
            IDLE: begin
                rearb = 1'b1;
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    rearb = 1'b1;
                end else if (cnt_q == '0) begin
                    if (!lock_hold) begin
                        rearb = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                rearb = 1'b1;
            end
        endcase

        if (rearb) begin
            if (pick_any) begin
                state_d = GRANT;
                sel_d   = pick_win;
                ptr_d   = pick_win;
                grant_d = onehot4(pick_win);
                valid_d = 1'b1;
                cnt_d   = DWELL_LOAD;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end

        switch_d = (sel_d != sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= SEL_W'(NUM_CH - 1);
            sel_q    <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign s0           = sel_q[0];
    assign s1           = sel_q[1];
    assign grant        = grant_q;
    assign valid        = valid_q;
    assign switch_pulse = switch_q;

endmodule

// File: tb/tb_mux_rr_select_seq.sv
// Bench for mux_rr_select_seq: directed phases with literal expectations plus random req traffic,
// all compared every cycle against a cycle-count model of the round-robin grant rules.
module tb_mux_rr_select_seq;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       lock;
    logic       s0, s1;
    logic [3:0] grant;
    logic       valid;
    logic       switch_pulse;

    int n_vec;
    int n_err;
    bit cmp_en;

    // model state
    bit m_busy;
    int m_owner;
    int m_held;
    int m_ptr;
    int m_sel;
    bit m_sw;

    mux_rr_select_seq #(.DWELL_CYCLES(DWELL), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
`ifdef MUX_SEQ_LOCK_EN
        .lock         (lock),
`endif
        .s0           (s0),
        .s1           (s1),
        .grant        (grant),
        .valid        (valid),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Model: a grant lives for DWELL visible cycles unless its requester drops or lock holds it.
    always @(posedge clk or negedge rst_n) begin : model
        int  prev;
        int  nxt;
        bit  end_g;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_held  = 0;
            m_ptr   = 3;
            m_sel   = 0;
            m_sw    = 1'b0;
        end else begin
            prev  = m_sel;
            end_g = 1'b0;
            if (m_busy) begin
                if (!req[m_owner]) end_g = 1'b1;
                else if (m_held >= DWELL && !lock) end_g = 1'b1;
                else if (m_held < DWELL) m_held++;
            end
            if (!m_busy || end_g) begin
                nxt = pick(req, m_ptr);
                if (nxt >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = nxt;
                    m_ptr   = nxt;
                    m_sel   = nxt;
                    m_held  = 1;
                end else begin
                    m_busy = 1'b0;
                end
            end
            m_sw = (m_sel != prev);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant", {28'd0, grant}, m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("model_valid", {31'd0, valid}, {31'd0, m_busy});
            chk("model_sel", {30'd0, s1, s0}, m_sel);
            chk("model_switch", {31'd0, switch_pulse}, {31'd0, m_sw});
        end
    end

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        lock   = 1'b0;
        cmp_en = 1'b0;
        n_vec  = 0;
        n_err  = 0;

        repeat (2) @(negedge clk);
        chk("reset_sel", {30'd0, s1, s0}, 32'd0);
        chk("reset_grant", {28'd0, grant}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_switch", {31'd0, switch_pulse}, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // single requester: continuous re-grant on channel 0, no pulses
        req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("solo_grant", {28'd0, grant}, 32'h1);
            chk("solo_valid", {31'd0, valid}, 32'd1);
            chk("solo_sel", {30'd0, s1, s0}, 32'd0);
            chk("solo_switch", {31'd0, switch_pulse}, 32'd0);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("idle_valid", {31'd0, valid}, 32'd0);

        // all requesting after channel 0 held: rotation 1,2,3,0 each for DWELL cycles
        req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("rot_sel", {30'd0, s1, s0}, (1 + i / DWELL) % 4);
            chk("rot_switch", {31'd0, switch_pulse}, (i % DWELL == 0) ? 32'd1 : 32'd0);
            chk("rot_valid", {31'd0, valid}, 32'd1);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        req = 4'b0101;
        repeat (12) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // early release: valid falls the cycle after req[1] drops
        req = 4'b0010;
        @(negedge clk);
        chk("early_grant1", {28'd0, grant}, 32'h2);
        @(negedge clk);
        chk("early_grant2", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        @(negedge clk);
        chk("early_valid", {31'd0, valid}, 32'd0);
        chk("early_grant0", {28'd0, grant}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
        end

        // asynchronous reset in the middle of a channel-2 grant
        req = 4'b0000;
        repeat (3) @(negedge clk);
        req = 4'b0100;
        repeat (2) @(negedge clk);
        chk("pre_rst_grant", {28'd0, grant}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", {28'd0, grant}, 32'd0);
        chk("async_rst_sel", {30'd0, s1, s0}, 32'd0);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        chk("post_rst_grant", {28'd0, grant}, 32'h1);
        chk("post_rst_sel", {30'd0, s1, s0}, 32'd0);

`ifdef MUX_SEQ_LOCK_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0011;
        lock  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lock_hold", {28'd0, grant}, 32'h1);
        end
        lock = 1'b0;
        @(negedge clk);
        chk("lock_release", {28'd0, grant}, 32'h2);
`endif

        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
